// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receive path.
// Holds the frame state encoding, the legal oversampling ratios and a legality helper.
package uart_rx_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } rx_state_t;

    localparam int unsigned PRESCALE_8  = 8;
    localparam int unsigned PRESCALE_16 = 16;
    localparam int unsigned PRESCALE_32 = 32;
    localparam int unsigned DATA_BITS   = 8;

    function automatic logic prescale_legal(input int unsigned p);
        return (p == PRESCALE_8) || (p == PRESCALE_16) || (p == PRESCALE_32);
    endfunction

endpackage

// File: rtl/edge_bit_counter.sv
// Oversampling edge counter and frame bit counter for the UART receiver.
// Counts while enabled, wraps the edge index at the end of each bit and advances the bit index.
module edge_bit_counter
    import uart_rx_pkg::*;
#(
    parameter int unsigned EDGE_W = 6,
    parameter int unsigned BIT_W  = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              enable,
    input  logic [EDGE_W-1:0] prescale,
    output logic [EDGE_W-1:0] edge_cnt,
    output logic [BIT_W-1:0]  bit_cnt,
    output logic              bit_end
);

    logic [EDGE_W-1:0] edge_q, edge_d;
    logic [BIT_W-1:0]  bit_q, bit_d;

    assign bit_end = (edge_q == prescale - EDGE_W'(1));

    always_comb begin
        edge_d = edge_q;
        bit_d  = bit_q;
        if (!enable) begin
            edge_d = '0;
            bit_d  = '0;
        end else if (bit_end) begin
            edge_d = '0;
            bit_d  = bit_q + BIT_W'(1);
        end else begin
            edge_d = edge_q + EDGE_W'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            edge_q <= '0;
            bit_q  <= '0;
        end else begin
            edge_q <= edge_d;
            bit_q  <= bit_d;
        end
    end

    assign edge_cnt = edge_q;
    assign bit_cnt  = bit_q;

endmodule

// File: rtl/uart_rx_fsm.sv
// UART receive frame controller: start detection, bit sequencing, deserialization and
// error pulses for one start bit, eight data bits, optional parity and one stop bit.
module uart_rx_fsm
    import uart_rx_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned EDGE_W = 6
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              RX_IN,
    input  logic              PAR_EN,
    input  logic [EDGE_W-1:0] Prescale,
    input  logic              sampled_bit,
    input  logic              par_err,
    output logic              samp_en,
    output logic              par_chk_en,
    output logic [EDGE_W-1:0] edge_cnt,
    output logic [3:0]        bit_cnt,
    output logic [DATA_W-1:0] P_DATA,
    output logic              data_valid,
    output logic              strt_glitch,
    output logic              stop_err
);

    localparam int unsigned IDX_W = $clog2(DATA_W);

    rx_state_t         state_q, state_d;
    logic              par_en_q;
    logic [EDGE_W-1:0] prescale_q;
    logic [EDGE_W-1:0] prescale_sel;
    logic              par_flag_q;
    logic [DATA_W-1:0] p_data_q;
    logic              cfg_load;
    logic              bit_end;
    logic              cnt_enable;
    logic [IDX_W-1:0]  data_idx;

    assign prescale_sel = prescale_legal(32'(Prescale)) ? Prescale : EDGE_W'(PRESCALE_8);

    // Counting starts on the start-detect cycle itself, so that cycle is edge 0.
    assign cnt_enable = (state_d != StIdle);

    edge_bit_counter #(
        .EDGE_W (EDGE_W),
        .BIT_W  (4)
    ) u_edge_bit_counter (
        .CLK      (CLK),
        .RST      (RST),
        .enable   (cnt_enable),
        .prescale (prescale_q),
        .edge_cnt (edge_cnt),
        .bit_cnt  (bit_cnt),
        .bit_end  (bit_end)
    );

    assign data_idx = IDX_W'(bit_cnt - 4'd1);

    always_comb begin
        state_d     = state_q;
        cfg_load    = 1'b0;
        data_valid  = 1'b0;
        strt_glitch = 1'b0;
        stop_err    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!RX_IN) begin
                    state_d  = StStart;
                    cfg_load = 1'b1;
                end
            end
            StStart: begin
                if (bit_end) begin
                    if (sampled_bit) begin
                        strt_glitch = 1'b1;
                        state_d     = StIdle;
                    end else begin
                        state_d = StData;
                    end
                end
            end
            StData: begin
                if (bit_end && (bit_cnt == 4'(DATA_BITS))) begin
                    state_d = par_en_q ? StParity : StStop;
                end
            end
            StParity: begin
                if (bit_end) begin
                    state_d = StStop;
                end
            end
            StStop: begin
                if (bit_end) begin
                    stop_err   = ~sampled_bit;
                    data_valid = sampled_bit & ~par_flag_q;
                    state_d    = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        if (!RST) begin
            state_d     = StIdle;
            cfg_load    = 1'b0;
            data_valid  = 1'b0;
            strt_glitch = 1'b0;
            stop_err    = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q    <= StIdle;
            par_en_q   <= 1'b0;
            prescale_q <= EDGE_W'(PRESCALE_8);
            par_flag_q <= 1'b0;
            p_data_q   <= '0;
        end else begin
            state_q <= state_d;
            if (cfg_load) begin
                par_en_q   <= PAR_EN;
                prescale_q <= prescale_sel;
            end
            if ((state_q == StData) && bit_end) begin
                p_data_q[data_idx] <= sampled_bit;
            end
            // The checker drops par_err one cycle after par_chk_en falls; edge 0 of STOP
            // is the last cycle its verdict is still on the wire.
            if ((state_q == StStop) && (edge_cnt == '0)) begin
                par_flag_q <= par_err & par_en_q;
            end
        end
    end

    assign samp_en    = (state_q != StIdle);
    assign par_chk_en = (state_q == StData) || (state_q == StParity);
    assign P_DATA     = p_data_q;

endmodule

// File: tb/tb_uart_rx_fsm.sv
// Self-checking bench for uart_rx_fsm: directed frame table, hand sequences and random frames,
// each cycle compared against a frame-level timing model computed from the bit/edge position.
module tb_uart_rx_fsm;

    logic       CLK = 1'b0;
    logic       RST;
    logic       RX_IN;
    logic       PAR_EN;
    logic [5:0] Prescale;
    logic       sampled_bit;
    logic       par_err;
    logic       samp_en;
    logic       par_chk_en;
    logic [5:0] edge_cnt;
    logic [3:0] bit_cnt;
    logic [7:0] P_DATA;
    logic       data_valid;
    logic       strt_glitch;
    logic       stop_err;

    always #5 CLK = ~CLK;

    uart_rx_fsm #(
        .DATA_W (8),
        .EDGE_W (6)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .RX_IN       (RX_IN),
        .PAR_EN      (PAR_EN),
        .Prescale    (Prescale),
        .sampled_bit (sampled_bit),
        .par_err     (par_err),
        .samp_en     (samp_en),
        .par_chk_en  (par_chk_en),
        .edge_cnt    (edge_cnt),
        .bit_cnt     (bit_cnt),
        .P_DATA      (P_DATA),
        .data_valid  (data_valid),
        .strt_glitch (strt_glitch),
        .stop_err    (stop_err)
    );

    typedef struct {
        logic [5:0] ps;
        logic       pe;
        logic [7:0] data;
        logic       stop;
        logic       glitch;
        logic       perr;
        int         gap;
    } frame_vec_t;

    localparam logic [22:0] ALL_MASK   = '1;
    localparam logic [22:0] PULSE_MASK = 23'h7;

    int         n_vec = 0;
    int         n_err = 0;
    logic [7:0] pd_model = 8'h00;

    function automatic logic rbit();
        return 1'($urandom % 2);
    endfunction

    function automatic int eff_prescale(input logic [5:0] ps);
        if (ps == 6'd8 || ps == 6'd16 || ps == 6'd32) return int'(ps);
        return 8;
    endfunction

    function automatic logic [22:0] pack_exp(input logic se, input logic pc, input logic [5:0] ec,
                                             input logic [3:0] bc, input logic [7:0] pd,
                                             input logic dv, input logic sg, input logic st);
        return {se, pc, ec, bc, pd, dv, sg, st};
    endfunction

    task automatic drive(input logic rst, input logic rx, input logic pe, input logic [5:0] ps,
                         input logic sb, input logic pr);
        @(negedge CLK);
        RST         = rst;
        RX_IN       = rx;
        PAR_EN      = pe;
        Prescale    = ps;
        sampled_bit = sb;
        par_err     = pr;
        #1;
    endtask

    task automatic check(input string tag, input int k, input logic [22:0] exp_v,
                         input logic [22:0] mask);
        logic [22:0] act;
        act = {samp_en, par_chk_en, edge_cnt, bit_cnt, P_DATA, data_valid, strt_glitch, stop_err};
        n_vec++;
        if ((act & mask) !== (exp_v & mask)) begin
            n_err++;
            $display("FAIL %s k=%0d: got %h required %h {samp,pchk,edge,bit,pdata,dv,sg,se}",
                     tag, k, act & mask, exp_v & mask);
        end
    endtask

    task automatic idle(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            drive(1'b1, 1'b1, rbit(), 6'($urandom), rbit(), rbit());
            check(tag, i, pack_exp(0, 0, 6'd0, 4'd0, pd_model, 0, 0, 0), ALL_MASK);
        end
    endtask

    // Expected outputs follow from the bit index b = k/P and edge e = k%P since start detect.
    task automatic run_frame(input frame_vec_t f, input string tag, input int abort_k);
        int   p;
        int   len;
        int   b;
        int   e;
        logic lb;
        logic rx;
        logic sb;
        logic pr;
        logic last;
        p   = eff_prescale(f.ps);
        len = f.glitch ? p : (10 + int'(f.pe)) * p;
        for (int k = 0; k < len; k++) begin
            b = k / p;
            e = k % p;
            if (b == 0)                lb = f.glitch;
            else if (b <= 8)           lb = f.data[b-1];
            else if (f.pe && b == 9)   lb = ^f.data;
            else                       lb = f.stop;
            if (k == 0 || (f.glitch && k == 1)) rx = 1'b0;
            else if (f.glitch)                  rx = 1'b1;
            else                                rx = rbit();
            sb = (e == p - 1) ? lb : rbit();
            if (f.pe && f.perr && k >= 9 * p + 8 && k <= 10 * p) pr = 1'b1;
            else if (f.pe && !f.glitch && k == len - p)         pr = f.perr;
            else                                                 pr = rbit();
            if (k == abort_k) begin
                drive(1'b0, rx, rbit(), 6'($urandom), sb, pr);
                check({tag, "_rst_cycle"}, k, 23'h0, PULSE_MASK);
                pd_model = 8'h00;
                return;
            end
            drive(1'b1, rx, (k == 0) ? f.pe : rbit(), (k == 0) ? f.ps : 6'($urandom), sb, pr);
            last = (k == len - 1);
            check(tag, k,
                  pack_exp(k > 0, (b >= 1 && b <= 8) || (f.pe && b == 9), 6'(e), 4'(b), pd_model,
                           last && !f.glitch && f.stop && !(f.pe && f.perr),
                           last && f.glitch,
                           last && !f.glitch && !f.stop),
                  ALL_MASK);
            if (e == p - 1 && b >= 1 && b <= 8) pd_model[b-1] = f.data[b-1];
        end
    endtask

    initial begin
        frame_vec_t dir[8];
        frame_vec_t fv;
        int         r;

        dir[0] = '{6'd8,  1'b0, 8'hA5, 1'b1, 1'b0, 1'b0, 2};  // clean frame
        dir[1] = '{6'd16, 1'b1, 8'h3C, 1'b1, 1'b0, 1'b1, 2};  // parity error
        dir[2] = '{6'd8,  1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 2};  // start glitch
        dir[3] = '{6'd32, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 2};  // framing error
        dir[4] = '{6'd8,  1'b0, 8'h55, 1'b1, 1'b0, 1'b0, 0};  // back-to-back first
        dir[5] = '{6'd8,  1'b0, 8'hFF, 1'b1, 1'b0, 1'b0, 3};  // back-to-back second
        dir[6] = '{6'd12, 1'b0, 8'hC3, 1'b1, 1'b0, 1'b0, 2};  // illegal prescale
        dir[7] = '{6'd16, 1'b1, 8'h96, 1'b1, 1'b0, 1'b0, 1};  // parity, no error

        drive(1'b0, 1'b1, 1'b0, 6'd8, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 6'd8, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b1, 6'd16, 1'b1, 1'b1);
        check("reset", 0, pack_exp(0, 0, 6'd0, 4'd0, 8'h00, 0, 0, 0), ALL_MASK);
        idle(3, "idle_after_reset");

        for (int i = 0; i < 8; i++) begin
            run_frame(dir[i], $sformatf("dir%0d", i), -1);
            idle(dir[i].gap, $sformatf("dir%0d_gap", i));
        end

        // Reset during DATA bit 4, then everything must read as freshly reset.
        fv = '{6'd8, 1'b0, 8'h5A, 1'b1, 1'b0, 1'b0, 0};
        run_frame(fv, "rst_mid", 4 * 8 + 3);
        idle(4, "after_rst_mid");

        for (int i = 0; i < 40; i++) begin
            r = int'($urandom % 5);
            fv.ps     = (r == 0) ? 6'd8 : (r == 1) ? 6'd16 : (r == 2) ? 6'd32 : 6'($urandom);
            fv.pe     = rbit();
            fv.data   = 8'($urandom);
            fv.stop   = (($urandom % 6) != 0);
            fv.glitch = (($urandom % 8) == 0);
            fv.perr   = rbit();
            fv.gap    = int'($urandom % 4);
            run_frame(fv, $sformatf("rnd%0d", i), -1);
            idle(fv.gap, $sformatf("rnd%0d_gap", i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
